// File: rtl/out_chk_pkg.sv
// Shared types and constants for the output sequence checker.
package out_chk_pkg;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCK   = 2'd2;
  localparam logic [1:0] ST_UNUSED = 2'd3;

  typedef enum logic [1:0] {
    SEARCH = ST_SEARCH,
    SYNC   = ST_SYNC,
    LOCK   = ST_LOCK,
    UNUSED = ST_UNUSED
  } chk_state_t;

endpackage

// File: rtl/out_seq_checker_if.sv
// Sample stream in, lock/error status out, for the sequence checker.
interface out_seq_checker_if #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 16
);
  import out_chk_pkg::*;

  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             clr_err;
  logic             locked;
  chk_state_t       state;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output data_in, valid_in, clr_err,
    input  locked, state, err_pulse, err_cnt
  );

  modport slave (
    input  data_in, valid_in, clr_err,
    output locked, state, err_pulse, err_cnt
  );
endinterface

// File: rtl/sat_cnt.sv
// Saturating event counter with synchronous clear; a clear coinciding
// with an event leaves the count at one so that event is not lost.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  // Count events, sticking at all-ones; clear wins over plain counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/out_seq_checker.sv
// Checks that a data stream is an incrementing sequence: acquires lock
// after LOCK_CNT consecutive matches, counts mismatches while locked and
// drops lock after MAX_MISS consecutive misses.
module out_seq_checker
  import out_chk_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int MAX_MISS = 3,
  parameter int ERR_W    = 16
) (
  input logic              ref_clk,
  input logic              rst,
  out_seq_checker_if.slave bus
);

  chk_state_t       state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [7:0]       match_q, match_d;
  logic [7:0]       miss_q, miss_d;
  logic             locked_q;
  logic             pulse_q, pulse_d;
  logic [ERR_W-1:0] err_cnt;

  logic [WIDTH-1:0] sample_next;
  logic [7:0]       match_inc;
  logic [7:0]       miss_inc;
  logic             hit;

  assign sample_next = bus.data_in + WIDTH'(1);
  assign match_inc   = match_q + 8'd1;
  assign miss_inc    = miss_q + 8'd1;
  assign hit         = (bus.data_in == expected_q);

  // Next-state and counter updates; idle cycles fall through holding everything.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    match_d    = match_q;
    miss_d     = miss_q;
    pulse_d    = 1'b0;
    case (state_q)
      SEARCH: begin
        if (bus.valid_in) begin
          expected_d = sample_next;
          match_d    = 8'd1;
          state_d    = SYNC;
        end
      end
      SYNC: begin
        if (bus.valid_in) begin
          expected_d = sample_next;
          if (hit) begin
            match_d = match_inc;
            if (match_inc >= 8'(LOCK_CNT)) begin
              state_d = LOCK;
            end
          end else begin
            match_d = 8'd1;
          end
        end
      end
      LOCK: begin
        if (bus.valid_in) begin
          if (hit) begin
            miss_d     = 8'd0;
            expected_d = sample_next;
          end else begin
            pulse_d    = 1'b1;
            expected_d = expected_q + WIDTH'(1);
            if (miss_inc >= 8'(MAX_MISS)) begin
              state_d = SEARCH;
              miss_d  = 8'd0;
              match_d = 8'd0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
      end
      default: begin
        state_d = SEARCH;
        match_d = 8'd0;
        miss_d  = 8'd0;
      end
    endcase
  end

  // State, tracking registers and registered status outputs.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state_q    <= SEARCH;
      expected_q <= '0;
      match_q    <= 8'd0;
      miss_q     <= 8'd0;
      locked_q   <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      locked_q   <= (state_d == LOCK);
      pulse_q    <= pulse_d;
    end
  end

  sat_cnt #(.W(ERR_W)) u_err_cnt (
    .clk (ref_clk),
    .rst (rst),
    .inc (pulse_d),
    .clr (bus.clr_err),
    .cnt (err_cnt)
  );

  assign bus.state     = state_q;
  assign bus.locked    = locked_q;
  assign bus.err_pulse = pulse_q;
  assign bus.err_cnt   = err_cnt;

endmodule

// File: tb/tb_out_seq_checker.sv
// Directed vector bench for out_seq_checker, plus a saturation sequence
// on a second instance with a narrow error counter.
module tb_out_seq_checker;
  import out_chk_pkg::*;

  logic ref_clk = 1'b0;
  logic rst;
  int   compared = 0;
  int   mismatched = 0;

  always #5 ref_clk = ~ref_clk;

  out_seq_checker_if #(.WIDTH(8), .ERR_W(16)) bus ();
  out_seq_checker_if #(.WIDTH(8), .ERR_W(3))  bus2 ();

  out_seq_checker #(.WIDTH(8), .LOCK_CNT(4), .MAX_MISS(3), .ERR_W(16)) dut (
    .ref_clk (ref_clk),
    .rst     (rst),
    .bus     (bus)
  );

  out_seq_checker #(.WIDTH(8), .LOCK_CNT(2), .MAX_MISS(20), .ERR_W(3)) dut_sat (
    .ref_clk (ref_clk),
    .rst     (rst),
    .bus     (bus2)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic        clr;
    logic        exp_locked;
    logic [1:0]  exp_state;
    logic        exp_pulse;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic v, input logic [7:0] d,
                         input logic c, input logic el, input logic [1:0] es,
                         input logic ep, input logic [15:0] ec);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.clr = c;
    t.exp_locked = el; t.exp_state = es; t.exp_pulse = ep; t.exp_cnt = ec;
    vecs.push_back(t);
  endtask

  task automatic check_val(input string name, input int idx,
                           input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s vec%0d: got %0h want %0h", name, idx, got, want);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst          = v.rst;
    bus.valid_in = v.valid;
    bus.data_in  = v.data;
    bus.clr_err  = v.clr;
    @(posedge ref_clk);
    #1;
  endtask

  task automatic check_output(input int idx, input vec_t v);
    check_val("locked", idx, 32'(bus.locked), 32'(v.exp_locked));
    check_val("state", idx, 32'(bus.state), 32'(v.exp_state));
    check_val("err_pulse", idx, 32'(bus.err_pulse), 32'(v.exp_pulse));
    check_val("err_cnt", idx, 32'(bus.err_cnt), 32'(v.exp_cnt));
  endtask

  initial begin
    rst = 1'b1;
    bus.valid_in = 1'b0; bus.data_in = 8'h00; bus.clr_err = 1'b0;
    bus2.valid_in = 1'b0; bus2.data_in = 8'h00; bus2.clr_err = 1'b0;

    // reset state
    add_vec(1, 0, 8'h00, 0, 0, ST_SEARCH, 0, 0);
    add_vec(1, 0, 8'h00, 0, 0, ST_SEARCH, 0, 0);
    // basic acquisition 0x10..0x13
    add_vec(0, 1, 8'h10, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h11, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h12, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h13, 0, 1, ST_LOCK, 0, 0);
    // reset beats valid and clear; first sample after reset is a search sample
    add_vec(1, 1, 8'h14, 1, 0, ST_SEARCH, 0, 0);
    add_vec(0, 1, 8'h50, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h51, 0, 0, ST_SYNC, 0, 0);
    // mismatch in SYNC restarts the run without an error
    add_vec(0, 1, 8'h60, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h61, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h62, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h63, 0, 1, ST_LOCK, 0, 0);
    // wrap-around while locked
    add_vec(1, 0, 8'h00, 0, 0, ST_SEARCH, 0, 0);
    add_vec(0, 1, 8'hFA, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'hFB, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'hFC, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'hFD, 0, 1, ST_LOCK, 0, 0);
    add_vec(0, 1, 8'hFE, 0, 1, ST_LOCK, 0, 0);
    add_vec(0, 1, 8'hFF, 0, 1, ST_LOCK, 0, 0);
    add_vec(0, 1, 8'h00, 0, 1, ST_LOCK, 0, 0);
    add_vec(0, 1, 8'h01, 0, 1, ST_LOCK, 0, 0);
    // single bad word then resync with free-running expectation
    add_vec(1, 0, 8'h00, 0, 0, ST_SEARCH, 0, 0);
    add_vec(0, 1, 8'h1D, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h1E, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h1F, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h20, 0, 1, ST_LOCK, 0, 0);
    add_vec(0, 1, 8'h55, 0, 1, ST_LOCK, 1, 1);
    add_vec(0, 1, 8'h22, 0, 1, ST_LOCK, 0, 1);
    add_vec(0, 1, 8'h23, 0, 1, ST_LOCK, 0, 1);
    add_vec(0, 0, 8'h55, 0, 1, ST_LOCK, 0, 1);
    // two misses, a match clears the miss run, two more misses
    add_vec(0, 1, 8'hAA, 0, 1, ST_LOCK, 1, 2);
    add_vec(0, 1, 8'hAA, 0, 1, ST_LOCK, 1, 3);
    add_vec(0, 1, 8'h26, 0, 1, ST_LOCK, 0, 3);
    add_vec(0, 1, 8'hAA, 0, 1, ST_LOCK, 1, 4);
    add_vec(0, 1, 8'hAA, 0, 1, ST_LOCK, 1, 5);
    add_vec(0, 1, 8'h29, 0, 1, ST_LOCK, 0, 5);
    // clear together with an error leaves one
    add_vec(0, 1, 8'hAA, 1, 1, ST_LOCK, 1, 1);
    // reset mid-lock
    add_vec(1, 1, 8'h2B, 0, 0, ST_SEARCH, 0, 0);
    // three consecutive misses lose lock
    add_vec(0, 1, 8'h30, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h31, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h32, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h33, 0, 1, ST_LOCK, 0, 0);
    add_vec(0, 1, 8'h99, 0, 1, ST_LOCK, 1, 1);
    add_vec(0, 1, 8'h99, 0, 1, ST_LOCK, 1, 2);
    add_vec(0, 1, 8'h99, 0, 0, ST_SEARCH, 1, 3);
    add_vec(0, 0, 8'h99, 0, 0, ST_SEARCH, 0, 3);
    // clear with no error
    add_vec(0, 0, 8'h99, 1, 0, ST_SEARCH, 0, 0);
    // idle cycle in SYNC is ignored
    add_vec(0, 1, 8'h99, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 0, 8'h9A, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h9A, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h9B, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h9C, 0, 1, ST_LOCK, 0, 0);
    // alternating valid while locked
    add_vec(1, 0, 8'h00, 0, 0, ST_SEARCH, 0, 0);
    add_vec(0, 1, 8'h3C, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h3D, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h3E, 0, 0, ST_SYNC, 0, 0);
    add_vec(0, 1, 8'h3F, 0, 1, ST_LOCK, 0, 0);
    for (int k = 0; k < 8; k++) begin
      add_vec(0, 1, 8'(8'h40 + k), 0, 1, ST_LOCK, 0, 0);
      add_vec(0, 0, 8'hEE, 0, 1, ST_LOCK, 0, 0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output(i, vecs[i]);
    end

    // Saturation on the 3-bit counter instance.
    bus.valid_in = 1'b0; bus.clr_err = 1'b0;
    rst = 1'b1;
    @(posedge ref_clk); #1;
    rst = 1'b0;
    bus2.valid_in = 1'b1; bus2.data_in = 8'h00;
    @(posedge ref_clk); #1;
    bus2.data_in = 8'h01;
    @(posedge ref_clk); #1;
    check_val("sat_locked", 0, 32'(bus2.locked), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      bus2.data_in = 8'hF0;
      @(posedge ref_clk); #1;
      check_val("sat_pulse", i, 32'(bus2.err_pulse), 32'd1);
      check_val("sat_cnt", i, 32'(bus2.err_cnt), (i < 7) ? 32'(i) : 32'd7);
      check_val("sat_state", i, 32'(bus2.state), 32'(ST_LOCK));
    end
    bus2.valid_in = 1'b0;
    @(posedge ref_clk); #1;
    check_val("sat_idle_pulse", 11, 32'(bus2.err_pulse), 32'd0);
    check_val("sat_idle_cnt", 11, 32'(bus2.err_cnt), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/out_seq_checker.md
OUT_SEQ_CHECKER -- requirements
Module: out_seq_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the data word width, matching the top-level `out` width.
REQ-002 The block SHALL have parameter LOCK_CNT, default 4, the number of consecutive in-sequence samples needed to declare lock (legal range 2..255).
REQ-003 The block SHALL have parameter MAX_MISS, default 3, the number of consecutive mismatches in LOCK that forces loss of lock (legal range 1..255).
REQ-004 The block SHALL have parameter ERR_W, default 16, the error counter width.
REQ-005 The block SHALL have port: ref_clk  input  1  sole clock, rising edge.
REQ-006 The block SHALL have port: rst  input  1  reset; one clock; synchronous, active-high.
REQ-007 The block SHALL have port: data_in  input  WIDTH  word from the top-level `out` stream.
REQ-008 The block SHALL have port: valid_in  input  1  data_in qualifier; 0 means the sample is ignored.
REQ-009 The block SHALL have port: clr_err  input  1  synchronous clear of err_cnt.
REQ-010 The block SHALL have port: locked  output  1  high while the FSM is in LOCK.
REQ-011 The block SHALL have port: state  output  2  current FSM state encoding.
REQ-012 The block SHALL have port: err_pulse  output  1  single-cycle strobe per counted error.
REQ-013 The block SHALL have port: err_cnt  output  ERR_W  saturating error count.

Function
REQ-014 The expected word SHALL be the previous accepted sample + 1 modulo 2^WIDTH, so all-ones followed by 0 is a match.
REQ-015 FSM states SHALL be SEARCH=0, SYNC=1, LOCK=2; encoding 3 SHALL be unreachable and SHALL recover to SEARCH on the next clock.
REQ-016 In SEARCH, on valid_in the block SHALL load expected=data_in+1 and match_cnt=1, then go to SYNC.
REQ-017 In SYNC, on a valid match the block SHALL increment match_cnt and set expected=data_in+1.
REQ-018 In SYNC, when match_cnt reaches LOCK_CNT the block SHALL enter LOCK.
REQ-019 In SYNC, on a valid mismatch the block SHALL reload expected=data_in+1 and match_cnt=1, stay in SYNC, and count no error.
REQ-020 In LOCK, on a valid match the block SHALL clear miss_cnt and set expected=data_in+1.
REQ-021 In LOCK, on a valid mismatch the block SHALL assert err_pulse, increment err_cnt, increment miss_cnt, and free-run expected=expected+1.
REQ-022 In LOCK, when miss_cnt reaches MAX_MISS the block SHALL go to SEARCH, drop locked, and clear miss_cnt and match_cnt.
REQ-023 When valid_in=0, the block SHALL hold all state, counters, and expected, and SHALL keep err_pulse at 0.
REQ-024 All outputs SHALL be registered, updating on the clock edge after the sample edge; latency from sample to locked/err_pulse/err_cnt is 1 cycle.
REQ-025 err_cnt SHALL saturate at 2^ERR_W-1; err_pulse SHALL still assert for errors while saturated.
REQ-026 When clr_err and an error occur in the same cycle, err_cnt SHALL become 1; when clr_err is set with no error, err_cnt SHALL become 0.
REQ-027 clr_err SHALL NOT affect the FSM, miss_cnt, or locked.

Reset
REQ-028 While rst=1, the block SHALL force state=SEARCH, locked=0, err_pulse=0, err_cnt=0, and match_cnt, miss_cnt and expected all 0.
REQ-029 rst SHALL take priority over valid_in and clr_err, including when asserted mid-LOCK.
REQ-030 On the first clock after rst deasserts, a valid sample SHALL be treated as a SEARCH sample.

Structure
REQ-031 Package out_chk_pkg SHALL hold the state enum typedef (chk_state_t) and the state encoding constants.
REQ-032 The design SHALL contain one sub-module, sat_cnt (parameter W; inc, clr inputs; saturating count output), used for err_cnt.

Verification
REQ-033 WIDTH=8: send valid words 0x10..0x13 -> locked=1 one cycle after 0x13; err_cnt=0.
REQ-034 WIDTH=8, locked: send 0xFE, 0xFF, 0x00, 0x01 -> locked stays 1; err_pulse never asserts.
REQ-035 Locked at 0x20: send 0x55, then 0x22, 0x23 -> exactly one err_pulse; err_cnt=1; locked stays 1.
REQ-036 Locked: send 3 consecutive bad words -> err_cnt=3; locked=0 and state=SEARCH one cycle after the 3rd word.
REQ-037 Locked, with valid_in toggling 1/0 on alternate cycles over 0x40..0x47 -> no errors; lock held; idle cycles change nothing.
REQ-038 With err_cnt=5: assert clr_err together with a bad word -> err_cnt=1; then assert rst mid-LOCK -> next cycle locked=0, err_cnt=0, state=SEARCH.
